// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits per clock
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cancel,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     operand_1,
    input  logic [WIDTH-1:0]     operand_2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result_mul
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(2 * WIDTH);
    localparam int PW    = WIDTH + BITS_PER_CYCLE;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [0:0]         state;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               sign;

    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [PW-1:0]      partial;
    logic [SH_W-1:0]    shamt;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] final_val;
    logic               zero_op;

    // Operands are reduced to magnitudes so the datapath is purely unsigned;
    // the sign is reapplied once on the completing edge.
    always_comb begin
        neg1      = operand_1[WIDTH-1] & ((mode == 2'b01) | (mode == 2'b10));
        neg2      = operand_2[WIDTH-1] & (mode == 2'b01);
        op1_mag   = neg1 ? -operand_1 : operand_1;
        op2_mag   = neg2 ? -operand_2 : operand_2;
        zero_op   = (operand_1 == '0) || (operand_2 == '0);
        partial   = {{BITS_PER_CYCLE{1'b0}}, mag1}
                  * {{WIDTH{1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
        shamt     = SH_W'(counter) * SH_W'(BITS_PER_CYCLE);
        acc_next  = acc + ((2*WIDTH)'(partial) << shamt);
        final_val = sign ? -acc_next : acc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            mag1       <= '0;
            mplier     <= '0;
            acc        <= '0;
            sign       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_mul <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !cancel) begin
                    if (zero_op) begin
                        result_mul <= '0;
                        done       <= 1'b1;
                    end else begin
                        mag1    <= op1_mag;
                        mplier  <= op2_mag;
                        sign    <= neg1 ^ neg2;
                        acc     <= '0;
                        counter <= '0;
                        state   <= CALC;
                        busy    <= 1'b1;
                    end
                end
            end else begin
                // A flush wins over completion so a cancelled op never reports done.
                if (cancel) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    acc     <= acc_next;
                    mplier  <= mplier >> BITS_PER_CYCLE;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST) begin
                        result_mul <= final_val;
                        done       <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cancel;
    logic [1:0]  mode;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        busy;
    logic        done;
    logic [63:0] result_mul;

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cancel     (cancel),
        .mode       (mode),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .busy       (busy),
        .done       (done),
        .result_mul (result_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        logic s1;
        logic s2;
        s1 = (m == 2'b01) || (m == 2'b10);
        s2 = (m == 2'b01);
        sa = $signed({{34{a[31] & s1}}, a});
        sb = $signed({{34{b[31] & s2}}, b});
        p  = sa * sb;
        return p[63:0];
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          output int lat, output int busy_cyc, output logic [63:0] res);
        operand_1 = a;
        operand_2 = b;
        mode      = m;
        start     = 1'b1;
        @(posedge clk);
        lat = 1;
        busy_cyc = 0;
        @(negedge clk);
        start     = 1'b0;
        operand_1 = $urandom;
        operand_2 = $urandom;
        mode      = 2'($urandom);
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result_mul;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] m, input logic [63:0] exp_res);
        int lat;
        int bc;
        logic [63:0] res;
        int exp_lat;
        int exp_bc;
        exp_lat = (a == 0 || b == 0) ? 1 : 9;
        exp_bc  = (a == 0 || b == 0) ? 0 : 8;
        run_op(a, b, m, lat, bc, res);
        total_cnt++;
        if (res !== exp_res)
            $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        else pass_cnt++;
        total_cnt++;
        if (lat !== exp_lat)
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (bc !== exp_bc)
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, exp_bc);
        else pass_cnt++;
    endtask

    task automatic expect_quiet(input string name, input int cycles, input logic [63:0] hold);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total_cnt++;
        if (seen != 0)
            $display("FAIL %s quiet: got %0d active cycles expected 0", name, seen);
        else pass_cnt++;
        total_cnt++;
        if (result_mul !== hold)
            $display("FAIL %s hold: got %h expected %h", name, result_mul, hold);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        cancel = 1'b0;
        mode = 2'b00;
        operand_1 = '0;
        operand_2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, result_mul} !== 66'd0)
            $display("FAIL reset: got busy=%b done=%b res=%h expected 0/0/0", busy, done, result_mul);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        check_op("umax",    32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFFFFFFFE00000001);
        check_op("s_m3x7",  32'hFFFFFFFD, 32'd7,        2'b01, 64'hFFFFFFFFFFFFFFEB);
        check_op("s_minsq", 32'h80000000, 32'h80000000, 2'b01, 64'h4000000000000000);
        check_op("s_m1m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'h0000000000000001);
        check_op("mixed",   32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFF00000001);
        check_op("mode11",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 64'hFFFFFFFE00000001);
    endtask

    task automatic test_zero;
        for (int m = 0; m < 4; m++)
            check_op("zero", 32'd0, 32'h12345678, 2'(m), 64'd0);
        check_op("zero_op2", 32'hDEADBEEF, 32'd0, 2'b01, 64'd0);
    endtask

    task automatic test_back_to_back;
        check_op("b2b_first", 32'd0, 32'h12345678, 2'b00, 64'd0);
        check_op("b2b_5x6",   32'd5, 32'd6,        2'b00, 64'd30);
        check_op("b2b_third", 32'd7, 32'hFFFFFFF9, 2'b01, 64'hFFFFFFFFFFFFFFCF);
    endtask

    task automatic test_cancel;
        check_op("pre_cancel", 32'd4, 32'd4, 2'b00, 64'd16);
        operand_1 = 32'd5;
        operand_2 = 32'd6;
        mode = 2'b00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL cancel_idle: got busy=%b done=%b expected 0/0", busy, done);
        else pass_cnt++;
        expect_quiet("cancel", 12, 64'd16);
    endtask

    task automatic test_ignore_start;
        int lat;
        lat = 1;
        operand_1 = 32'd7;
        operand_2 = 32'd9;
        mode = 2'b00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        operand_1 = 32'd3;
        operand_2 = 32'd3;
        repeat (2) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total_cnt++;
        if (lat !== 9)
            $display("FAIL ignore_start latency: got %0d expected 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (result_mul !== 64'd63)
            $display("FAIL ignore_start result: got %h expected %h", result_mul, 64'd63);
        else pass_cnt++;
        expect_quiet("ignore_start", 12, 64'd63);
    endtask

    task automatic test_start_cancel_idle;
        logic [63:0] hold;
        hold = result_mul;
        operand_1 = 32'd11;
        operand_2 = 32'd13;
        start = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL start_cancel: got busy=%b done=%b expected 0/0", busy, done);
        else pass_cnt++;
        expect_quiet("start_cancel", 10, hold);
    endtask

    task automatic test_reset_midop;
        operand_1 = 32'h0000FFFF;
        operand_2 = 32'h00012345;
        mode = 2'b00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, result_mul} !== 66'd0)
            $display("FAIL reset_midop: got busy=%b done=%b res=%h expected 0/0/0", busy, done, result_mul);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_op("after_reset", 32'd2, 32'd3, 2'b00, 64'd6);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            m = 2'($urandom);
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'h80000000;
                2: a = 32'($urandom_range(0, 3));
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            check_op("random", a, b, m, ref_mul(a, b, m));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero();
        test_back_to_back();
        test_cancel();
        test_ignore_start();
        test_start_cancel_idle();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
